// File: rtl/flofifo2.sv
// flofifo2: single-clock circular FIFO with occupancy count, standard or
// first-word-fall-through read, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and synchronous flush.
module flofifo2 #(
    parameter int LENGTH    = 32,
    parameter int WIDTH     = 24,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = LENGTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         err_clr_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         valid_i,
    input  logic                         read_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    output logic [$clog2(LENGTH+1)-1:0]  locs_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int AW = $clog2(LENGTH);
    localparam int CW = $clog2(LENGTH + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(LENGTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    // Elaboration-time parameter sanity checks
    if ((LENGTH < 4) || ((LENGTH & (LENGTH - 1)) != 0)) begin : g_bad_length
        $error("flofifo2: LENGTH must be a power of two >= 4");
    end
    if ((AE_THRESH < 0) || (AE_THRESH >= AF_THRESH) || (AF_THRESH > LENGTH)) begin : g_bad_thresh
        $error("flofifo2: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= LENGTH");
    end

    logic [WIDTH-1:0] mem [LENGTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic wr_acc;
    logic rd_acc;
    logic ovf_evt;
    logic unf_evt;

    // Flags come only from the registered count; a flush masks all requests.
    assign locs_o         = count;
    assign empty_o        = (count == '0);
    assign full_o         = (count == FULL_CNT);
    assign almost_full_o  = (count >= AF_CNT);
    assign almost_empty_o = (count <= AE_CNT);

    assign wr_acc  = valid_i && !full_o  && !flush_i;
    assign rd_acc  = read_i  && !empty_o && !flush_i;
    assign ovf_evt = valid_i && full_o   && !flush_i;
    assign unf_evt = read_i  && empty_o  && !flush_i;

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a same-cycle error event wins over err_clr_i
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= (overflow_o  && !err_clr_i) || ovf_evt;
            underflow_o <= (underflow_o && !err_clr_i) || unf_evt;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly from the RAM
        assign data_o  = mem[rd_ptr];
        assign valid_o = !empty_o;
    end else begin : g_std
        logic [WIDTH-1:0] data_q;
        logic             valid_q;

        // Registered read: popped word with a one-cycle valid pulse
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) data_q <= mem[rd_ptr];
            end
        end

        assign data_o  = data_q;
        assign valid_o = valid_q;
    end

endmodule

// File: tb/tb_flofifo2.sv
// Self-checking bench for flofifo2: standard-mode instance checked via a
// scoreboard queue, plus a small FWFT instance checked directly.
module tb_flofifo2;

    localparam int W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          flush_i = 0, err_clr_i = 0, valid_i = 0, read_i = 0;
    logic [W-1:0]  data_i = '0;
    logic [W-1:0]  data_o;
    logic          valid_o, empty_o, full_o, almost_full_o, almost_empty_o;
    logic          overflow_o, underflow_o;
    logic [3:0]    locs_o;

    logic          f_valid_i = 0, f_read_i = 0;
    logic [W-1:0]  f_data_i = '0;
    logic [W-1:0]  f_data_o;
    logic          f_valid_o, f_empty_o, f_full_o, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]    f_locs_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];
    bit mon_en = 0;

    always #5 clk = ~clk;

    flofifo2 #(.LENGTH(8), .WIDTH(W), .FWFT(0), .AF_THRESH(4), .AE_THRESH(2)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .err_clr_i(err_clr_i),
        .data_i(data_i), .valid_i(valid_i), .read_i(read_i),
        .data_o(data_o), .valid_o(valid_o), .locs_o(locs_o),
        .empty_o(empty_o), .full_o(full_o), .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o)
    );

    flofifo2 #(.LENGTH(8), .WIDTH(W), .FWFT(1), .AF_THRESH(4), .AE_THRESH(2)) dut_fwft (
        .clk(clk), .rst(rst), .flush_i(1'b0), .err_clr_i(1'b0),
        .data_i(f_data_i), .valid_i(f_valid_i), .read_i(f_read_i),
        .data_o(f_data_o), .valid_o(f_valid_o), .locs_o(f_locs_o),
        .empty_o(f_empty_o), .full_o(f_full_o), .almost_full_o(f_af),
        .almost_empty_o(f_ae), .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid_o pulse must match the oldest expected word
    always @(negedge clk) begin
        if (mon_en && valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got data 0x%0h required no valid_o", data_o);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    errors++;
                    $display("FAIL read_data: got 0x%0h required 0x%0h", data_o, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        rst = 0;
        // Reset state
        chk("rst_locs", locs_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_af", almost_full_o, 0);
        chk("rst_ae", almost_empty_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_unf", underflow_o, 0);
        mon_en = 1;

        // 1: single write, idle, single read
        valid_i = 1; data_i = 24'h000001;
        step();
        valid_i = 0;
        chk("t1_locs_after_write", locs_o, 1);
        repeat (7) step();
        read_i = 1; exp_q.push_back(24'h000001);
        step();
        read_i = 0;
        chk("t1_valid_pulse", valid_o, 1);
        chk("t1_locs_after_read", locs_o, 0);
        chk("t1_empty", empty_o, 1);
        step();
        chk("t1_valid_drop", valid_o, 0);

        // 2: fill, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            valid_i = 1; data_i = W'(i);
            step();
            if (i == 2) chk("t2_ae_at_2", almost_empty_o, 1);
            if (i == 3) begin
                chk("t2_ae_at_3", almost_empty_o, 0);
                chk("t2_af_at_3", almost_full_o, 0);
            end
            if (i == 4) chk("t2_af_at_4", almost_full_o, 1);
        end
        chk("t2_locs_full", locs_o, 8);
        chk("t2_full", full_o, 1);
        chk("t2_af", almost_full_o, 1);
        chk("t2_ovf_before", overflow_o, 0);
        data_i = 24'h0000AA;
        step();
        valid_i = 0;
        chk("t2_ovf", overflow_o, 1);
        chk("t2_locs_after_drop", locs_o, 8);
        for (int i = 1; i <= 8; i++) begin
            read_i = 1; exp_q.push_back(W'(i));
            step();
        end
        read_i = 0;
        chk("t2_locs_drained", locs_o, 0);
        chk("t2_empty", empty_o, 1);
        step();
        err_clr_i = 1;
        step();
        err_clr_i = 0;
        chk("t2_ovf_cleared", overflow_o, 0);

        // 3: wrap-around with overlapping read+write
        for (int r = 0; r < 3; r++) begin
            int base;
            int exp_locs [7];
            exp_locs = '{1, 2, 2, 2, 2, 1, 0};
            base = 1 + 5 * r;
            for (int c = 0; c < 7; c++) begin
                valid_i = (c < 5);
                data_i  = W'(base + c);
                read_i  = (c >= 2);
                if (c >= 2) exp_q.push_back(W'(base + c - 2));
                step();
                if (r == 1) chk("t3_locs", locs_o, exp_locs[c]);
            end
            valid_i = 0; read_i = 0;
        end
        step();
        chk("t3_ovf", overflow_o, 0);
        chk("t3_unf", underflow_o, 0);
        chk("t3_empty", empty_o, 1);

        // 5: read and write while empty
        read_i = 1; valid_i = 1; data_i = 24'h000077;
        step();
        read_i = 0; valid_i = 0;
        chk("t5_unf", underflow_o, 1);
        chk("t5_locs", locs_o, 1);
        chk("t5_ovf", overflow_o, 0);
        step();
        chk("t5_no_valid", valid_o, 0);
        err_clr_i = 1;
        step();
        err_clr_i = 0;
        chk("t5_unf_cleared", underflow_o, 0);
        read_i = 1; exp_q.push_back(24'h000077);
        step();
        read_i = 0;
        step();
        chk("t5_empty", empty_o, 1);

        // 6: flush with pending requests, overflow retained
        for (int i = 0; i < 8; i++) begin
            valid_i = 1; data_i = W'(24'h100 + i);
            step();
        end
        data_i = 24'h1FF;
        step();
        valid_i = 0;
        chk("t6_ovf_set", overflow_o, 1);
        for (int i = 0; i < 2; i++) begin
            read_i = 1; exp_q.push_back(W'(24'h100 + i));
            step();
        end
        read_i = 0;
        chk("t6_locs_6", locs_o, 6);
        flush_i = 1; valid_i = 1; read_i = 1; data_i = 24'h000003;
        step();
        flush_i = 0; valid_i = 0; read_i = 0;
        chk("t6_locs", locs_o, 0);
        chk("t6_empty", empty_o, 1);
        chk("t6_valid", valid_o, 0);
        chk("t6_ovf_kept", overflow_o, 1);
        chk("t6_unf", underflow_o, 0);
        step();
        chk("t6_locs_idle", locs_o, 0);
        valid_i = 1; data_i = 24'h000055;
        step();
        valid_i = 0;
        read_i = 1; exp_q.push_back(24'h000055);
        step();
        read_i = 0;
        step();

        // Reset mid-burst with requests held
        valid_i = 1; data_i = 24'h000061;
        step();
        data_i = 24'h000062;
        step();
        rst = 1; read_i = 1; err_clr_i = 0;
        step();
        chk("rr_locs", locs_o, 0);
        chk("rr_empty", empty_o, 1);
        chk("rr_ae", almost_empty_o, 1);
        chk("rr_full", full_o, 0);
        chk("rr_af", almost_full_o, 0);
        chk("rr_valid", valid_o, 0);
        chk("rr_data", data_o, 0);
        chk("rr_ovf", overflow_o, 0);
        chk("rr_unf", underflow_o, 0);
        rst = 0; valid_i = 0; read_i = 0;
        step();
        chk("rr_locs_after", locs_o, 0);

        // 4: FWFT instance
        chk("t4_empty_valid", f_valid_o, 0);
        f_valid_i = 1; f_data_i = 24'h123456;
        step();
        f_valid_i = 0;
        chk("t4_valid", f_valid_o, 1);
        chk("t4_data", f_data_o, 24'h123456);
        step();
        chk("t4_valid_held", f_valid_o, 1);
        f_read_i = 1;
        step();
        f_read_i = 0;
        chk("t4_valid_after_read", f_valid_o, 0);
        f_valid_i = 1; f_data_i = 24'h0000A1;
        step();
        f_data_i = 24'h0000B2;
        step();
        f_valid_i = 0;
        chk("t4_head_a", f_data_o, 24'h0000A1);
        f_read_i = 1;
        step();
        f_read_i = 0;
        chk("t4_head_b", f_data_o, 24'h0000B2);
        chk("t4_valid_b", f_valid_o, 1);
        chk("t4_locs_b", f_locs_o, 1);

        step();
        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
